maxp_layer_ctrl: RTL and testbench
==================================

Name: maxp_layer_ctrl

Overview:
- Sequences the max-pooling engine (maxp) over all channel feature maps of one layer.
- Per channel: computes source and destination base addresses, drives matrix/matrix2, holds maxp_en until the engine raises STOP plus a drain tail, then drops maxp_en for one gap cycle so the engine self-clears.
- Sits between the top-level layer FSM (go/done handshake) and one maxp instance.

Parameters:
- SIZE_address_pix, 13, width of pixel-memory addresses.
- CH_W, 6, width of the channel-count input (max 2^CH_W-1 channels).
- TAIL_CYC, 2, cycles maxp_en stays high after STOP to land the final write.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- go  in  1  start request; sampled only in IDLE
- layer_channels  in  CH_W  number of channel maps to pool
- matrix_in  in  5  input map side length (even, >=2)
- src_base  in  SIZE_address_pix  address of channel 0 input map
- dst_base  in  SIZE_address_pix  address of channel 0 output map
- STOP  in  1  engine end-of-map flag (level, held until maxp_en low)
- maxp_en  out  1  engine enable
- memstartp  out  SIZE_address_pix  current channel input base
- memstartzap  out  SIZE_address_pix  current channel output base
- matrix  out  5  registered copy of matrix_in
- matrix2  out  10  matrix*matrix - matrix - 2, registered
- busy  out  1  high from accepted go until done
- done  out  1  one-cycle pulse at layer end
- err  out  1  sticky config-error flag, cleared on next accepted go

Behaviour:
- Reset (async, immediate): state IDLE; maxp_en, busy, done, err = 0; memstartp, memstartzap, matrix, matrix2 = 0; channel counter = 0.
- States: IDLE, SETUP, RUN, TAIL, GAP, DONE.
- IDLE: go=1 -> latch layer_channels, matrix_in, src_base, dst_base; clear err; busy=1; -> SETUP. go while busy is ignored.
- SETUP (1 cycle):
  - matrix_in odd or <2 -> err=1, -> DONE.
  - layer_channels==0 -> -> DONE, err stays 0.
  - Otherwise: memstartp=src_base, memstartzap=dst_base, matrix=matrix_in, matrix2 computed (10-bit, unsigned) -> RUN.
- RUN: maxp_en=1. STOP sampled high -> TAIL with tail counter = TAIL_CYC-1. If TAIL_CYC==0, go straight to GAP.
- TAIL: maxp_en stays 1; counter decrements; at 0 -> GAP.
- GAP (exactly 1 cycle): maxp_en=0.
  - Channel counter increments.
  - If new count == layer_channels -> DONE.
  - Else memstartp += matrix*matrix and memstartzap += (matrix/2)*(matrix/2), both via precomputed per-layer step registers (no per-cycle multiply). Adds wrap modulo 2^SIZE_address_pix. -> RUN.
- DONE: done=1 for one cycle; busy=0 in the same cycle; -> IDLE.
- Latency:
  - go to first maxp_en = 2 cycles.
  - Last STOP to done = TAIL_CYC+2 cycles.
- memstartp/memstartzap/matrix/matrix2 are stable for the whole time maxp_en is high.
- STOP asserted outside RUN is ignored. STOP still high entering a new RUN cannot occur, because GAP guarantees en-low clears it.
- Reset mid-layer: immediate abort; maxp_en drops asynchronously; no done pulse.

Optional Feature:
- Macro: MAXP_CTRL_PERF_EN.
- Defined: adds output perf_cycles (24 bits).
  - Cleared on accepted go.
  - Increments every cycle while busy; saturates at all-ones.
  - Holds its value after done until the next go.
- Undefined: port and counter absent. All other behaviour identical.

Test Plan:
- Reset mid-RUN (ch 1 of 4) -> maxp_en=0 same cycle, busy=0, no done, next go restarts at src_base.
- matrix_in=28, channels=4, src_base=0, dst_base=4000, engine model STOP after 100 en-cycles:
  - memstartp sequence 0,784,1568,2352; memstartzap 4000,4196,4392,4588.
  - matrix2=754.
  - Exactly 4 GAP cycles with maxp_en=0.
  - done one pulse, 4*(100+2+1)+2 cycles after go.
- channels=0 -> done 2 cycles after go, maxp_en never high, err=0.
- matrix_in=7 -> err=1, done pulse, maxp_en never high; next go with matrix_in=4 clears err.
- src_base=8000, matrix=28, channels=2, SIZE_address_pix=13 -> second memstartp = 8784 mod 8192 = 592.
- go held high through DONE -> second layer starts only after return to IDLE; STOP pulse injected in IDLE -> no effect.

Source files
------------

// File: rtl/maxp_layer_ctrl.sv
// Layer sequencer for the max-pooling engine: walks every channel map of a layer.
// Optional MAXP_CTRL_PERF_EN adds a saturating busy-cycle counter (perf_cycles).
module maxp_layer_ctrl #(
  parameter int unsigned SIZE_address_pix = 13,
  parameter int unsigned CH_W             = 6,
  parameter int unsigned TAIL_CYC         = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        go,
  input  logic [CH_W-1:0]             layer_channels,
  input  logic [4:0]                  matrix_in,
  input  logic [SIZE_address_pix-1:0] src_base,
  input  logic [SIZE_address_pix-1:0] dst_base,
  input  logic                        STOP,
  output logic                        maxp_en,
  output logic [SIZE_address_pix-1:0] memstartp,
  output logic [SIZE_address_pix-1:0] memstartzap,
  output logic [4:0]                  matrix,
  output logic [9:0]                  matrix2,
  output logic                        busy,
  output logic                        done,
  output logic                        err
`ifdef MAXP_CTRL_PERF_EN
  ,
  output logic [23:0]                 perf_cycles
`endif
);

  localparam int unsigned AW        = SIZE_address_pix;
  localparam int unsigned TAIL_W    = (TAIL_CYC > 1) ? $clog2(TAIL_CYC) : 1;
  localparam int unsigned TAIL_INIT = (TAIL_CYC > 0) ? (TAIL_CYC - 1) : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_TAIL,
    S_GAP,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [CH_W-1:0]     r_ch_total;
  logic [CH_W-1:0]     r_ch_cnt;
  logic [4:0]          r_mat_in;
  logic [AW-1:0]       r_src;
  logic [AW-1:0]       r_dst;
  logic [AW-1:0]       r_step_p;
  logic [AW-1:0]       r_step_z;
  logic [TAIL_W-1:0]   r_tail_cnt;

  logic                w_cfg_bad;
  logic [CH_W-1:0]     w_ch_next;
  logic [9:0]          w_sq;
  logic [9:0]          w_half_sq;
  logic                w_en_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  assign w_cfg_bad = r_mat_in[0] | (r_mat_in < 5'd2);
  assign w_ch_next = r_ch_cnt + CH_W'(1);
  // Per-layer products; only captured once in SETUP, never on the channel loop.
  assign w_sq      = 10'(r_mat_in) * 10'(r_mat_in);
  assign w_half_sq = 10'(r_mat_in[4:1]) * 10'(r_mat_in[4:1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (go) w_next = S_SETUP;
      S_SETUP: begin
        if (w_cfg_bad)                   w_next = S_DONE;
        else if (r_ch_total == '0)       w_next = S_DONE;
        else                             w_next = S_RUN;
      end
      S_RUN: begin
        if (STOP) begin
          if (TAIL_CYC == 0) w_next = S_GAP;
          else               w_next = S_TAIL;
        end
      end
      S_TAIL:  if (r_tail_cnt == '0) w_next = S_GAP;
      S_GAP: begin
        if (w_ch_next == r_ch_total) w_next = S_DONE;
        else                         w_next = S_RUN;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control outputs registered from the next state so they align with it.
  assign w_en_nxt   = (w_next == S_RUN) || (w_next == S_TAIL);
  assign w_busy_nxt = (w_next == S_SETUP) || (w_next == S_RUN) ||
                      (w_next == S_TAIL)  || (w_next == S_GAP);
  assign w_done_nxt = (w_next == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maxp_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      memstartp   <= '0;
      memstartzap <= '0;
      matrix      <= '0;
      matrix2     <= '0;
      r_ch_total  <= '0;
      r_ch_cnt    <= '0;
      r_mat_in    <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_step_p    <= '0;
      r_step_z    <= '0;
      r_tail_cnt  <= '0;
    end else begin
      maxp_en <= w_en_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_ch_total <= layer_channels;
            r_mat_in   <= matrix_in;
            r_src      <= src_base;
            r_dst      <= dst_base;
            r_ch_cnt   <= '0;
            err        <= 1'b0;
          end
        end
        S_SETUP: begin
          if (w_cfg_bad) begin
            err <= 1'b1;
          end else if (r_ch_total != '0) begin
            memstartp   <= r_src;
            memstartzap <= r_dst;
            matrix      <= r_mat_in;
            matrix2     <= w_sq - 10'(r_mat_in) - 10'd2;
            r_step_p    <= AW'(w_sq);
            r_step_z    <= AW'(w_half_sq);
          end
        end
        S_RUN:  if (STOP) r_tail_cnt <= TAIL_W'(TAIL_INIT);
        S_TAIL: if (r_tail_cnt != '0) r_tail_cnt <= r_tail_cnt - TAIL_W'(1);
        S_GAP: begin
          r_ch_cnt <= w_ch_next;
          if (w_ch_next != r_ch_total) begin
            memstartp   <= memstartp + r_step_p;
            memstartzap <= memstartzap + r_step_z;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MAXP_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                perf_cycles <= '0;
    else if ((r_state == S_IDLE) && go)     perf_cycles <= '0;
    else if (busy && (perf_cycles != '1))   perf_cycles <= perf_cycles + 24'd1;
  end
`endif

endmodule

// File: tb/tb_maxp_layer_ctrl.sv
// Bench for maxp_layer_ctrl: vector table of layer configs, per-channel address
// scoreboard, plus hand-written reset-abort and go-held sequences.
module tb_maxp_layer_ctrl;

  localparam int unsigned SA = 13;
  localparam int unsigned CW = 6;
  localparam int unsigned TC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [CW-1:0] layer_channels;
  logic [4:0]    matrix_in;
  logic [SA-1:0] src_base;
  logic [SA-1:0] dst_base;
  logic          STOP;
  logic          maxp_en;
  logic [SA-1:0] memstartp;
  logic [SA-1:0] memstartzap;
  logic [4:0]    matrix;
  logic [9:0]    matrix2;
  logic          busy;
  logic          done;
  logic          err;
`ifdef MAXP_CTRL_PERF_EN
  logic [23:0]   perf_cycles;
`endif

  maxp_layer_ctrl #(.SIZE_address_pix(SA), .CH_W(CW), .TAIL_CYC(TC)) dut (
    .clk(clk), .rst(rst), .go(go), .layer_channels(layer_channels),
    .matrix_in(matrix_in), .src_base(src_base), .dst_base(dst_base),
    .STOP(STOP), .maxp_en(maxp_en), .memstartp(memstartp),
    .memstartzap(memstartzap), .matrix(matrix), .matrix2(matrix2),
    .busy(busy), .done(done), .err(err)
`ifdef MAXP_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine model: raises STOP after stop_after enabled cycles, holds it until en drops.
  int   stop_after = 100;
  int   en_cnt;
  logic model_stop;
  logic stop_force = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      en_cnt     <= 0;
      model_stop <= 1'b0;
    end else if (!maxp_en) begin
      en_cnt     <= 0;
      model_stop <= 1'b0;
    end else begin
      en_cnt <= en_cnt + 1;
      if (en_cnt + 1 >= stop_after - 1) model_stop <= 1'b1;
    end
  end

  assign STOP = model_stop | stop_force;

  typedef struct {
    logic [SA-1:0] p;
    logic [SA-1:0] z;
    logic [4:0]    m;
    logic [9:0]    m2;
  } exp_t;

  exp_t sbq[$];

  // Monitor: pop expected addresses at every channel start, check stability while enabled.
  logic          prev_en = 1'b0;
  logic          unstable = 1'b0;
  logic [SA-1:0] cap_p, cap_z;
  int            en_rises = 0;
  int            gaps = 0;
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (maxp_en && !prev_en) begin
      exp_t e;
      en_rises++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_run: got channel start expected none (t=%0t)", $time);
      end else begin
        e = sbq.pop_front();
        chk("memstartp", 32'(memstartp), 32'(e.p));
        chk("memstartzap", 32'(memstartzap), 32'(e.z));
        chk("matrix", 32'(matrix), 32'(e.m));
        chk("matrix2", 32'(matrix2), 32'(e.m2));
      end
      cap_p    = memstartp;
      cap_z    = memstartzap;
      unstable = 1'b0;
    end else if (maxp_en) begin
      if (memstartp !== cap_p || memstartzap !== cap_z) unstable = 1'b1;
    end else if (prev_en) begin
      gaps++;
      chk("addr_stable", 32'(unstable), 32'd0);
    end
    if (done) done_cnt++;
    prev_en = maxp_en;
  end

  typedef struct {
    int   mat;
    int   ch;
    int   src;
    int   dst;
    int   n;
    logic exp_err;
    int   exp_m2;
    int   exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic push_layer(input vec_t v);
    exp_t e;
    if ((v.mat % 2) == 0 && v.mat >= 2) begin
      for (int k = 0; k < v.ch; k++) begin
        e.p  = SA'(v.src + k * v.mat * v.mat);
        e.z  = SA'(v.dst + k * (v.mat / 2) * (v.mat / 2));
        e.m  = 5'(v.mat);
        e.m2 = 10'(v.exp_m2);
        sbq.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input int limit, output int lat, input int start);
    bit seen = 1'b0;
    lat = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = cyc - start;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles", limit);
    end
  endtask

  task automatic run_layer(input vec_t v, input string tag);
    int start, lat, exp_runs;
    exp_runs = (v.exp_err) ? 0 : v.ch;
    push_layer(v);
    stop_after = v.n;
    en_rises = 0;
    gaps = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    matrix_in      = 5'(v.mat);
    layer_channels = CW'(v.ch);
    src_base       = SA'(v.src);
    dst_base       = SA'(v.dst);
    go             = 1'b1;
    start          = cyc;
    @(posedge clk); #1;
    go = 1'b0;
    chk({tag, "_busy_after_go"}, 32'(busy), 32'd1);
    wait_done(v.exp_lat + 40, lat, start);
    chk({tag, "_done_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_one_pulse"}, 32'(done), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_channel_runs"}, 32'(en_rises), 32'(exp_runs));
    chk({tag, "_gap_cycles"}, 32'(gaps), 32'(exp_runs));
    chk({tag, "_sb_drained"}, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lat, start;
    bit   seen;

    vecs[0] = '{28, 4, 0,    4000, 100, 1'b0, 754, 414};
    vecs[1] = '{28, 0, 0,    4000, 5,   1'b0, 754, 2};
    vecs[2] = '{7,  3, 0,    0,    5,   1'b1, 0,   2};
    vecs[3] = '{4,  1, 16,   32,   5,   1'b0, 10,  10};
    vecs[4] = '{28, 2, 8000, 100,  6,   1'b0, 754, 20};
    vecs[5] = '{0,  2, 0,    0,    5,   1'b1, 0,   2};
    vecs[6] = '{2,  3, 8190, 8191, 4,   1'b0, 0,   23};
    vecs[7] = '{30, 1, 0,    0,    3,   1'b0, 868, 8};

    go = 1'b0; layer_channels = '0; matrix_in = '0; src_base = '0; dst_base = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_maxp_en", 32'(maxp_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_memstartp", 32'(memstartp), 32'd0);
    chk("rst_memstartzap", 32'(memstartzap), 32'd0);
    chk("rst_matrix2", 32'(matrix2), 32'd0);
    @(negedge clk); #2 rst = 1'b0;

    for (int i = 0; i < 8; i++) run_layer(vecs[i], $sformatf("vec%0d", i));

    // Reset during channel 1 of 4 aborts at once, then a fresh go restarts at src_base.
    v = '{4, 4, 100, 200, 10, 1'b0, 10, 0};
    push_layer(v);
    stop_after = 10;
    en_rises = 0;
    @(posedge clk); #1;
    matrix_in = 5'd4; layer_channels = CW'(4); src_base = SA'(100); dst_base = SA'(200);
    go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (en_rises >= 2) seen = 1'b1;
    end
    chk("abort_reached_ch1", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_en_before_rst", 32'(maxp_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_en_async", 32'(maxp_en), 32'd0);
    chk("abort_busy_async", 32'(busy), 32'd0);
    done_cnt = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    sbq.delete();
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    run_layer('{4, 2, 100, 200, 5, 1'b0, 10, 18}, "restart");

    // go held through DONE: the second layer begins only after one IDLE cycle.
    v = '{4, 1, 50, 60, 3, 1'b0, 10, 8};
    push_layer(v);
    push_layer(v);
    stop_after = 3;
    en_rises = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    matrix_in = 5'd4; layer_channels = CW'(1); src_base = SA'(50); dst_base = SA'(60);
    go = 1'b1;
    start = cyc;
    wait_done(60, lat, start);
    chk("held_done_latency", 32'(lat), 32'd8);
    @(negedge clk);
    chk("held_idle_busy", 32'(busy), 32'd0);
    chk("held_idle_en", 32'(maxp_en), 32'd0);
    @(negedge clk);
    chk("held_setup_busy", 32'(busy), 32'd1);
    chk("held_setup_en", 32'(maxp_en), 32'd0);
    @(negedge clk);
    chk("held_second_run", 32'(maxp_en), 32'd1);
    @(posedge clk); #1 go = 1'b0;
    start = cyc - 3;
    wait_done(60, lat, start);
    chk("held_second_latency", 32'(lat), 32'd8);
    @(negedge clk);
    chk("held_done_count", 32'(done_cnt), 32'd2);
    chk("held_runs", 32'(en_rises), 32'd2);
    chk("held_sb_drained", 32'(sbq.size()), 32'd0);

    // A STOP pulse while idle must not start anything.
    done_cnt = 0;
    en_rises = 0;
    @(posedge clk); #1 stop_force = 1'b1;
    @(posedge clk); #1 stop_force = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_stop_busy", 32'(busy), 32'd0);
      chk("idle_stop_en", 32'(maxp_en), 32'd0);
    end
    chk("idle_stop_no_done", 32'(done_cnt), 32'd0);
    chk("idle_stop_no_run", 32'(en_rises), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
